class_accumulator_seq: RTL and testbench

- Parametrised, sequential successor to the combinational chunk adder used in class-hypervector training.
- Holds CLASSES class hypervectors as LANES-wide chunks of saturating CNT_W-bit counters in an internal flop array.
- Accepts one sparse binary query chunk per handshake beat and adds it to, or subtracts it from, the selected class across NUM_CHUNKS beats.
- Also provides per-class clear and a registered read-out port for the similarity and search stages.

---
 rtl/class_accumulator_seq.sv | 190 +++++++++++++++++++
 tb/tb_class_accumulator_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/class_accumulator_seq.sv
// class_accumulator_seq
// Sequential class-hypervector accumulator. Each class hypervector is stored as
// NUM_CHUNKS words of LANES saturating CNT_W-bit counters. A pass streams one
// binary query chunk per handshake beat into the selected class, adding or
// subtracting one per set lane. A clear walks the class and zeroes it one chunk
// per cycle. A registered read port serves the similarity/search stages while
// the block is idle.
module class_accumulator_seq #(
    parameter int LANES      = 5,
    parameter int CNT_W      = 8,
    parameter int NUM_CHUNKS = 16,
    parameter int CLASSES    = 2,
    localparam int CLS_W     = (CLASSES > 1) ? $clog2(CLASSES) : 1,
    localparam int CH_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int WORD_W    = LANES * CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [CLS_W-1:0]  cls_sel,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANES-1:0]  in_chunk,
    input  logic              rd_en,
    input  logic [CLS_W-1:0]  rd_cls,
    input  logic [CH_W-1:0]   rd_chunk,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);

    // Controller states (plain constants so older tools and scripts can match them)
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CH_W-1:0]  LAST_CHNK = CH_W'(NUM_CHUNKS - 1);

    logic [1:0]        state;
    logic [CLS_W-1:0]  cls_q;      // class owning the current pass or clear
    logic              mode_q;     // 0 = add, 1 = subtract, frozen for the pass
    logic [CH_W-1:0]   chunk_idx;  // chunk being accumulated or cleared

    // Counter storage: one word per (class, chunk), lane i at [i*CNT_W +: CNT_W]
    logic [WORD_W-1:0] mem [CLASSES][NUM_CHUNKS];

    logic [WORD_W-1:0] cur_word;   // stored word at the active chunk
    logic [WORD_W-1:0] acc_word;   // that word after applying the current beat
    logic              acc_sat;    // some set lane was already at its limit
    logic [WORD_W-1:0] rd_word;    // read-port lookup, zero when out of range
    logic              cmd_ok;     // cls_sel names an existing class
    logic              rd_ok;      // rd_cls/rd_chunk name an existing word
    logic              is_last;    // active chunk is the final one of the class
    logic              beat;       // accumulate handshake fires this cycle

    // Range checks are done at 32 bits so they stay meaningful for any CLASSES
    function automatic logic cls_in_range(input logic [CLS_W-1:0] c);
        return (32'(c) < 32'(CLASSES));
    endfunction

    function automatic logic chunk_in_range(input logic [CH_W-1:0] k);
        return (32'(k) < 32'(NUM_CHUNKS));
    endfunction

    assign in_ready = (state == S_ACCUM);
    assign busy     = (state != S_IDLE);
    assign cmd_ok   = cls_in_range(cls_sel);
    assign rd_ok    = cls_in_range(rd_cls) && chunk_in_range(rd_chunk);
    assign is_last  = (chunk_idx == LAST_CHNK);
    assign beat     = in_valid && in_ready;

    // Per-lane saturating add/subtract of the incoming chunk onto the stored word
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cur_word = mem[cls_q][chunk_idx];
        acc_word = cur_word;
        acc_sat  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_chunk[i]) begin
                if (!mode_q) begin
                    if (cur_word[i*CNT_W +: CNT_W] == CNT_MAX) begin
                        acc_sat = 1'b1;
                    end else begin
                        acc_word[i*CNT_W +: CNT_W] = cur_word[i*CNT_W +: CNT_W] + CNT_W'(1);
                    end
                end else begin
                    if (cur_word[i*CNT_W +: CNT_W] == '0) begin
                        acc_sat = 1'b1;
                    end else begin
                        acc_word[i*CNT_W +: CNT_W] = cur_word[i*CNT_W +: CNT_W] - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Read-port lookup; out-of-range requests return an all-zero word
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[rd_cls][rd_chunk];
        end
    end

    // Controller: command decode, chunk sequencing, pulses and sticky saturation
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= S_IDLE;
            cls_q     <= '0;
            mode_q    <= 1'b0;
            chunk_idx <= '0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_en) begin
                        rd_data  <= rd_word;
                        rd_valid <= 1'b1;
                    end
                    // clear takes priority over a simultaneous start
                    if (cmd_ok && (clear || start)) begin
                        cls_q     <= cls_sel;
                        chunk_idx <= '0;
                        sat_flag  <= 1'b0;
                        if (clear) begin
                            state <= S_CLEAR;
                        end else begin
                            mode_q <= mode;
                            state  <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        if (acc_sat) begin
                            sat_flag <= 1'b1;
                        end
                        if (is_last) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            chunk_idx <= chunk_idx + CH_W'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    if (is_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        chunk_idx <= chunk_idx + CH_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Counter array: read-modify-write on each beat, one zeroed chunk per clear cycle
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the counter array is reset explicitly because an aborted pass must not leave
        // partial sums behind; this keeps it in flops rather than a RAM macro.
        if (rst) begin
            for (int c = 0; c < CLASSES; c++) begin
                for (int k = 0; k < NUM_CHUNKS; k++) begin
                    mem[c][k] <= '0;
                end
            end
        end else if (beat) begin
            mem[cls_q][chunk_idx] <= acc_word;
        end else if (state == S_CLEAR) begin
            mem[cls_q][chunk_idx] <= '0;
        end
    end

endmodule

// File: tb/tb_class_accumulator_seq.sv
// tb_class_accumulator_seq
// Self-checking bench for class_accumulator_seq with LANES=5, CNT_W=8,
// NUM_CHUNKS=4, CLASSES=2. The reference keeps every counter as a plain int
// and applies the saturating +1/-1 rule lane by lane; reads are compared
// against words packed from that model.
module tb_class_accumulator_seq;

    localparam int LANES      = 5;
    localparam int CNT_W      = 8;
    localparam int NUM_CHUNKS = 4;
    localparam int CLASSES    = 2;
    localparam int CLS_W      = 1;
    localparam int CH_W       = 2;
    localparam int WORD_W     = LANES * CNT_W;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              clear;
    logic [CLS_W-1:0]  cls_sel;
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [LANES-1:0]  in_chunk;
    logic              rd_en;
    logic [CLS_W-1:0]  rd_cls;
    logic [CH_W-1:0]   rd_chunk;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              sat_flag;

    class_accumulator_seq #(
        .LANES(LANES), .CNT_W(CNT_W), .NUM_CHUNKS(NUM_CHUNKS), .CLASSES(CLASSES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .cls_sel(cls_sel),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_chunk(in_chunk),
        .rd_en(rd_en), .rd_cls(rd_cls), .rd_chunk(rd_chunk), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counter value per class, chunk and lane
    int model [CLASSES][NUM_CHUNKS][LANES];
    bit model_sat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] model_word(input int c, input int k);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i*CNT_W +: CNT_W] = CNT_W'(model[c][k][i]);
        end
        return w;
    endfunction

    task automatic model_zero_all();
        for (int c = 0; c < CLASSES; c++)
            for (int k = 0; k < NUM_CHUNKS; k++)
                for (int i = 0; i < LANES; i++)
                    model[c][k][i] = 0;
        model_sat = 1'b0;
    endtask

    // Issue one read in IDLE and compare the returned word against the model
    task automatic read_chk(input int c, input int k);
        rd_en    = 1'b1;
        rd_cls   = CLS_W'(c);
        rd_chunk = CH_W'(k);
        @(negedge clk);
        rd_en = 1'b0;
        check($sformatf("rd_valid c%0d k%0d", c, k), 64'(rd_valid), 64'(1));
        check($sformatf("rd_data c%0d k%0d", c, k), 64'(rd_data), 64'(model_word(c, k)));
    endtask

    task automatic read_all(input string phase);
        for (int c = 0; c < CLASSES; c++)
            for (int k = 0; k < NUM_CHUNKS; k++)
                read_chk(c, k);
        @(negedge clk);
        check({phase, " rd_valid drops"}, 64'(rd_valid), 64'(0));
        check({phase, " rd_data holds"}, 64'(rd_data), 64'(model_word(CLASSES-1, NUM_CHUNKS-1)));
    endtask

    // One accumulate pass; beat k is beats[k*LANES +: LANES]. With poke set, the first
    // gap cycle before each beat also pulses start and rd_en, which must be ignored.
    task automatic run_pass(input int c, input bit md, input logic [19:0] beats,
                            input int gap, input bit poke);
        logic [LANES-1:0] b;
        start   = 1'b1;
        cls_sel = CLS_W'(c);
        mode    = md;
        @(negedge clk);
        start = 1'b0;
        check("in_ready at pass start", 64'(in_ready), 64'(1));
        check("busy at pass start", 64'(busy), 64'(1));
        model_sat = 1'b0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            for (int g = 0; g < gap; g++) begin
                if (poke && g == 0) begin
                    start    = 1'b1;
                    cls_sel  = CLS_W'(c + 1);
                    mode     = ~md;
                    rd_en    = 1'b1;
                    rd_cls   = CLS_W'(c);
                    rd_chunk = CH_W'(k);
                end
                @(negedge clk);
                if (poke && g == 0) begin
                    start = 1'b0;
                    rd_en = 1'b0;
                    check("rd ignored mid-pass", 64'(rd_valid), 64'(0));
                    check("still busy mid-pass", 64'(busy), 64'(1));
                end
            end
            b        = beats[k*LANES +: LANES];
            in_valid = 1'b1;
            in_chunk = b;
            for (int i = 0; i < LANES; i++) begin
                if (b[i]) begin
                    if (!md) begin
                        if (model[c][k][i] == CNT_MAX) model_sat = 1'b1;
                        else model[c][k][i] = model[c][k][i] + 1;
                    end else begin
                        if (model[c][k][i] == 0) model_sat = 1'b1;
                        else model[c][k][i] = model[c][k][i] - 1;
                    end
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_chunk = '0;
            if (k < NUM_CHUNKS - 1) check("no early done", 64'(done), 64'(0));
        end
        check("done after last beat", 64'(done), 64'(1));
        check("idle after pass", 64'(busy), 64'(0));
        check("sat_flag after pass", 64'(sat_flag), 64'(model_sat));
    endtask

    // Clear one class: busy for NUM_CHUNKS cycles, then a done pulse
    task automatic run_clear(input int c);
        clear   = 1'b1;
        cls_sel = CLS_W'(c);
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            check($sformatf("clear busy cyc%0d", k), 64'(busy), 64'(1));
            check($sformatf("clear in_ready cyc%0d", k), 64'(in_ready), 64'(0));
            check($sformatf("clear done low cyc%0d", k), 64'(done), 64'(0));
            @(negedge clk);
        end
        check("clear done", 64'(done), 64'(1));
        check("clear idle", 64'(busy), 64'(0));
        for (int k = 0; k < NUM_CHUNKS; k++)
            for (int i = 0; i < LANES; i++)
                model[c][k][i] = 0;
        model_sat = 1'b0;
        check("clear sat_flag", 64'(sat_flag), 64'(model_sat));
    endtask

    localparam logic [19:0] SCEN1 = {5'b01010, 5'b10101, 5'b00000, 5'b11111};

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; cls_sel = '0; mode = 1'b0;
        in_valid = 1'b0; in_chunk = '0; rd_en = 1'b0; rd_cls = '0; rd_chunk = '0;
        model_zero_all();
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset rd_valid", 64'(rd_valid), 64'(0));
        check("reset sat_flag", 64'(sat_flag), 64'(0));
        check("reset rd_data", 64'(rd_data), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        read_all("reset");

        // Scenario 1: fixed beats into class 0, then confirm a clear leaves class 1 alone
        run_pass(0, 1'b0, SCEN1, 0, 1'b0);
        @(negedge clk);
        check("done is one pulse", 64'(done), 64'(0));
        read_all("scen1");
        run_pass(1, 1'b0, 20'($urandom), 1, 1'b0);
        run_clear(0);
        read_all("clear0");

        // Subtract on an empty chunk clips at zero
        run_pass(0, 1'b1, 20'b00001, 0, 1'b0);
        read_all("sub-sat");

        // Drive class 1 to saturation with all-ones passes
        run_clear(1);
        for (int p = 1; p <= 257; p++) begin
            run_pass(1, 1'b0, 20'hFFFFF, 0, 1'b0);
        end
        read_all("sat");

        // Back-pressure with ignored start/rd_en pokes reproduces scenario 1
        run_clear(0);
        run_pass(0, 1'b0, SCEN1, 3, 1'b1);
        read_all("gaps");

        // Randomised passes and clears against the model
        for (int r = 0; r < 40; r++) begin
            int c;
            c = int'($urandom_range(0, CLASSES - 1));
            if ($urandom_range(0, 9) == 0) begin
                run_clear(c);
            end else begin
                run_pass(c, 1'($urandom_range(0, 1)), 20'($urandom),
                         int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
            read_chk(int'($urandom_range(0, CLASSES - 1)), int'($urandom_range(0, NUM_CHUNKS - 1)));
        end
        read_all("random");

        // Reset after beat 2 aborts the pass and wipes all counters
        start = 1'b1; cls_sel = '0; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_chunk = 5'b11111;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        in_valid = 1'b0;
        model_zero_all();
        check("abort busy", 64'(busy), 64'(0));
        check("abort in_ready", 64'(in_ready), 64'(0));
        check("abort rd_data", 64'(rd_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("abort no done", 64'(done), 64'(0));
            @(negedge clk);
        end
        read_all("abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
